// File: rtl/boss_attack_scheduler_pkg.sv
// Shared encodings and constants for the boss attack scheduler.
// Holds state/attack codes, slot count, LFSR seed/taps and attack type selection.
package boss_pkg;

  localparam int NUM_SLOTS    = 5;
  localparam int SLOT_CNT_W   = $clog2(NUM_SLOTS + 1);
  localparam int SPREAD_COUNT = 3;
  localparam int BURST_COUNT  = 3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 of a left-shifting Fibonacci LFSR (bit 7 is tap 8).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COOLDOWN,
    S_TELEGRAPH,
    S_FIRE,
    S_DEAD
  } state_t;

  typedef enum logic [1:0] {
    ATK_SINGLE  = 2'd0,
    ATK_SPREAD  = 2'd1,
    ATK_BURST   = 2'd2,
    ATK_BARRAGE = 2'd3
  } attack_t;

  function automatic attack_t pick_type(input logic       force_en,
                                        input logic [1:0] force_type,
                                        input logic [1:0] ph,
                                        input logic [1:0] rnd);
    attack_t t;
    if (force_en) begin
      t = attack_t'(force_type);
    end else begin
      case (ph)
        2'd0:    t = attack_t'({1'b0, rnd[0]});
        2'd1:    t = (rnd == 2'd3) ? ATK_BURST : attack_t'(rnd);
        default: t = attack_t'(rnd);
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/boss_attack_scheduler_slot_picker.sv
// Combinational: selects the lowest-index n bits that are set in the free mask.
// Fewer than n bits are returned when fewer are free.
module slot_picker
  import boss_pkg::*;
(
  input  logic [NUM_SLOTS-1:0]  free_i,
  input  logic [SLOT_CNT_W-1:0] n_i,
  output logic [NUM_SLOTS-1:0]  mask_o
);

  logic [SLOT_CNT_W-1:0] taken;

  always_comb begin
    mask_o = '0;
    taken  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free_i[i] && (taken < n_i)) begin
        mask_o[i] = 1'b1;
        taken     = taken + 1'b1;
      end
    end
  end

endmodule

// File: rtl/boss_attack_scheduler.sv
// Boss attack sequencer: cooldown -> telegraph -> fire, all timing in cycleStep ticks.
// Spawn pulses are registered; a volley with no free slot waits in FIRE for a later tick.
module boss_attack_scheduler
  import boss_pkg::*;
#(
  parameter int HP_W            = 10,
  parameter int PHASE2_HP       = 300,
  parameter int PHASE3_HP       = 150,
  parameter int TELEGRAPH_TICKS = 2
) (
  input  logic                 clk_master,
  input  logic                 rst,
  input  logic                 pulse_cycleStep,
  input  logic                 enable,
  input  logic [HP_W-1:0]      bossHP,
  input  logic [31:0]          delay,
  input  logic [NUM_SLOTS-1:0] slotBusy,
  input  logic                 forceTypeEn,
  input  logic [1:0]           forceType,
  output logic [NUM_SLOTS-1:0] spawnMask,
  output logic                 bossShoot,
  output logic [1:0]           attackType,
  output logic [1:0]           phase,
  output logic                 indicate1,
  output logic                 busy
);

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            shots_q, shots_d;
  attack_t               type_q, type_d;
  logic [NUM_SLOTS-1:0]  spawn_q, spawn_d;
  logic                  shoot_q;
  logic [1:0]            phase_q, phase_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [31:0]           delay_sh, cool_load;
  logic [SLOT_CNT_W-1:0] pick_n;
  logic [NUM_SLOTS-1:0]  grant;

  always_comb begin
    if (bossHP > HP_W'(PHASE2_HP)) begin
      phase_d = 2'd0;
    end else if (bossHP > HP_W'(PHASE3_HP)) begin
      phase_d = 2'd1;
    end else begin
      phase_d = 2'd2;
    end
  end

  assign lfsr_d    = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  assign delay_sh  = delay >> phase_q;
  assign cool_load = (delay_sh == 32'd0) ? 32'd1 : delay_sh;

  always_comb begin
    case (type_q)
      ATK_SPREAD:  pick_n = SLOT_CNT_W'(SPREAD_COUNT);
      ATK_BARRAGE: pick_n = SLOT_CNT_W'(NUM_SLOTS);
      default:     pick_n = SLOT_CNT_W'(1);
    endcase
  end

  slot_picker u_slot_picker (
    .free_i (~slotBusy),
    .n_i    (pick_n),
    .mask_o (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shots_d = shots_q;
    type_d  = type_q;
    spawn_d = '0;

    // Death wins over everything, then a dropped enable aborts without spawning.
    if (state_q == S_DEAD) begin
      state_d = S_DEAD;
    end else if ((state_q != S_IDLE) && (bossHP == '0)) begin
      state_d = S_DEAD;
    end else if ((state_q != S_IDLE) && !enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_COOLDOWN;
            cnt_d   = cool_load;
          end
        end
        S_COOLDOWN: begin
          if (pulse_cycleStep) begin
            if (cnt_q == 32'd1) begin
              state_d = S_TELEGRAPH;
              type_d  = pick_type(forceTypeEn, forceType, phase_q, lfsr_q[1:0]);
              cnt_d   = 32'(TELEGRAPH_TICKS);
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        S_TELEGRAPH: begin
          if (pulse_cycleStep) begin
            if (cnt_q == 32'd1) begin
              state_d = S_FIRE;
              shots_d = (type_q == ATK_BURST) ? 2'(BURST_COUNT) : 2'd1;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        S_FIRE: begin
          if (pulse_cycleStep && (grant != '0)) begin
            spawn_d = grant;
            if ((type_q == ATK_BURST) && (shots_q != 2'd1)) begin
              shots_d = shots_q - 2'd1;
            end else begin
              shots_d = '0;
              state_d = S_COOLDOWN;
              cnt_d   = cool_load;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shots_q <= '0;
      type_q  <= ATK_SINGLE;
      spawn_q <= '0;
      shoot_q <= 1'b0;
      phase_q <= 2'd0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shots_q <= shots_d;
      type_q  <= type_d;
      spawn_q <= spawn_d;
      shoot_q <= |spawn_d;
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign spawnMask  = spawn_q;
  assign bossShoot  = shoot_q;
  assign attackType = type_q;
  assign phase      = phase_q;
  assign indicate1  = (state_q == S_TELEGRAPH);
  assign busy       = (state_q == S_TELEGRAPH) || (state_q == S_FIRE);

endmodule
